block_rle_encoder: RTL and testbench

Encoder-side counterpart of the dequantizing table generator. It accepts one 8x8 block of signed 8-bit coefficients and quantizes each with the standard luminance table. It zig-zag scans the block and emits the (run, coefficient) symbol stream that the decoder-side table generator consumes, including DC differential coding, ZRL (15,0) and EOB (0,0). It sits between the forward-transform stage and the entropy coder.

---
 rtl/jpeg_codec_pkg.sv | 48 ++++
 rtl/coef_quantizer.sv | 28 ++
 rtl/block_rle_encoder.sv | 138 +++++++++++++
 tb/tb_block_rle_encoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_codec_pkg.sv
// Shared JPEG codec constants: zig-zag order, luminance quantizer table and its
// 16-bit rounded reciprocals, symbol constants and the encoder state type.
package jpeg_codec_pkg;

  localparam int COEF_W  = 8;
  localparam int BLOCK_N = 64;

  localparam logic [3:0] EOB_RUN = 4'd0;
  localparam logic [3:0] ZRL_RUN = 4'd15;

  // Zig-zag position k -> raster index.
  localparam logic [5:0] ZIGZAG [BLOCK_N] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  localparam logic [7:0] QUANT [BLOCK_N] = '{
    16,  11,  10,  16,  24,  40,  51,  61,
    12,  12,  14,  19,  26,  58,  60,  55,
    14,  13,  16,  24,  40,  57,  69,  56,
    14,  17,  22,  29,  51,  87,  80,  62,
    18,  22,  37,  56,  68, 109, 103,  77,
    24,  35,  55,  64,  81, 104, 113,  92,
    49,  64,  78,  87, 103, 121, 120, 101,
    72,  92,  95,  98, 112, 100, 103,  99
  };

  // round(65536 / QUANT[i]), raster order.
  localparam logic [15:0] RECIP [BLOCK_N] = '{
    4096, 5958, 6554, 4096, 2731, 1638, 1285, 1074,
    5461, 5461, 4681, 3449, 2521, 1130, 1092, 1192,
    4681, 5041, 4096, 2731, 1638, 1150,  950, 1170,
    4681, 3855, 2979, 2260, 1285,  753,  819, 1057,
    3641, 2979, 1771, 1170,  964,  601,  636,  851,
    2731, 1872, 1192, 1024,  809,  630,  580,  712,
    1337, 1024,  840,  753,  636,  542,  546,  649,
     910,  712,  690,  669,  585,  655,  636,  662
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_QUANT,
    ST_EMIT
  } enc_state_t;

endpackage

// File: rtl/coef_quantizer.sv
// Combinational reciprocal quantizer: q = sat8((x*R + 32768) >>> 16), or x when bypassed.
module coef_quantizer
  import jpeg_codec_pkg::*;
(
  input  logic [COEF_W-1:0] x,
  input  logic [15:0]       recip,
  input  logic              bypass,
  output logic [COEF_W-1:0] q
);

  logic signed [24:0] prod;
  logic signed [24:0] scaled;

  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    prod   = $signed({{17{x[7]}}, x}) * $signed({9'd0, recip}) + 25'sd32768;
    scaled = prod >>> 16;
    if (bypass)
      q = x;
    else if (scaled > 25'sd127)
      q = 8'h7F;
    else if (scaled < -25'sd128)
      q = 8'h80;
    else
      q = scaled[7:0];
  end

endmodule

// File: rtl/block_rle_encoder.sv
// 8x8 block quantizer + zig-zag run-length symbol generator with DC differential,
// ZRL and EOB. One symbol per cycle; outputs registered and held under backpressure.
module block_rle_encoder
  import jpeg_codec_pkg::*;
#(
  parameter bit BYPASS_QUANT = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BLOCK_N*COEF_W-1:0] block_in,
  input  logic                      block_valid,
  output logic                      block_ready,
  output logic [3:0]                r_value,
  output logic [COEF_W-1:0]         coefficient,
  output logic                      coef_valid,
  input  logic                      coef_ready,
  output logic                      last
);

  enc_state_t                state;
  logic [BLOCK_N*COEF_W-1:0] blk;
  logic [COEF_W-1:0]         slot [BLOCK_N];
  logic [5:0]                k;
  logic [5:0]                zz;
  logic [5:0]                lastnz;
  logic [COEF_W-1:0]         qk;
  logic [COEF_W-1:0]         prev_dc;
  logic [6:0]                p;
  logic [6:0]                cand;
  logic [5:0]                hit;
  logic [3:0]                run_n;
  logic                      found;

  assign zz = ZIGZAG[k];

  coef_quantizer u_quant (
    .x      (blk[{zz, 3'b000} +: COEF_W]),
    .recip  (RECIP[zz]),
    .bypass (BYPASS_QUANT),
    .q      (qk)
  );

  // First nonzero slot within the next 16 positions that does not pass lastnz.
  always_comb begin
    found = 1'b0;
    run_n = '0;
    hit   = '0;
    cand  = '0;
    for (int j = 0; j < 16; j++) begin
      cand = p + 7'(j);
      if (!found && cand <= {1'b0, lastnz} && slot[cand[5:0]] != '0) begin
        found = 1'b1;
        run_n = 4'(j);
        hit   = cand[5:0];
      end
    end
  end

  // NOTE: the block and slot buffers have no reset; each entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && block_valid)
      blk <= block_in;
    if (state == ST_QUANT)
      slot[k] <= qk;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      block_ready <= 1'b1;
      coef_valid  <= 1'b0;
      r_value     <= '0;
      coefficient <= '0;
      last        <= 1'b0;
      k           <= '0;
      p           <= '0;
      lastnz      <= '0;
      prev_dc     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (block_valid) begin
            state       <= ST_QUANT;
            block_ready <= 1'b0;
            k           <= '0;
            lastnz      <= '0;
          end
        end

        ST_QUANT: begin
          if (k != '0 && qk != '0)
            lastnz <= k;
          k <= k + 6'd1;
          if (k == 6'd63) begin
            state <= ST_EMIT;
            p     <= '0;
          end
        end

        ST_EMIT: begin
          if (coef_valid && coef_ready && last) begin
            state       <= ST_IDLE;
            block_ready <= 1'b1;
            coef_valid  <= 1'b0;
            last        <= 1'b0;
          end else if (!coef_valid || coef_ready) begin
            coef_valid <= 1'b1;
            if (p == '0) begin
              r_value     <= 4'd0;
              coefficient <= slot[0] - prev_dc;
              prev_dc     <= slot[0];
              last        <= 1'b0;
              p           <= 7'd1;
            end else if (p > {1'b0, lastnz}) begin
              r_value     <= EOB_RUN;
              coefficient <= '0;
              last        <= 1'b1;
            end else if (found) begin
              r_value     <= run_n;
              coefficient <= slot[hit];
              last        <= (hit == 6'd63);
              p           <= {1'b0, hit} + 7'd1;
            end else begin
              r_value     <= ZRL_RUN;
              coefficient <= '0;
              last        <= 1'b0;
              p           <= p + 7'd16;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_rle_encoder.sv
// Scoreboard bench: directed blocks push hand-computed symbols; per-DUT monitors pop and compare.
`timescale 1ns/1ps
module tb_block_rle_encoder;

  typedef struct packed {
    logic [3:0] r;
    logic [7:0] c;
    logic       l;
  } sym_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] block_in;

  logic       valid_a, ready_a, cv_a, cr_a, last_a;
  logic [3:0] r_a;
  logic [7:0] c_a;
  logic       valid_b, ready_b, cv_b, cr_b, last_b;
  logic [3:0] r_b;
  logic [7:0] c_b;

  sym_t q_a[$];
  sym_t q_b[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  block_rle_encoder #(.BYPASS_QUANT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .block_in(block_in), .block_valid(valid_a), .block_ready(ready_a),
    .r_value(r_a), .coefficient(c_a), .coef_valid(cv_a), .coef_ready(cr_a), .last(last_a)
  );

  block_rle_encoder #(.BYPASS_QUANT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .block_in(block_in), .block_valid(valid_b), .block_ready(ready_b),
    .r_value(r_b), .coefficient(c_b), .coef_valid(cv_b), .coef_ready(cr_b), .last(last_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic expect_sym(input bit sel, input logic [3:0] r, input logic [7:0] c, input logic l);
    sym_t s;
    s.r = r;
    s.c = c;
    s.l = l;
    if (sel) q_b.push_back(s);
    else     q_a.push_back(s);
  endtask

  // Present a block, wait for acceptance and check first-symbol latency.
  task automatic send(input bit sel, input logic [511:0] b);
    int n;
    block_in = b;
    if (sel) valid_b = 1'b1;
    else     valid_a = 1'b1;
    n = 0;
    while (!(sel ? ready_b : ready_a) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(sel ? cv_b : cv_a) && n < 200);
    check(sel ? "latency_b" : "latency_a", 32'(n), 32'd65);
  endtask

  task automatic wait_done(input bit sel);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? (q_b.size() == 0 && ready_b) : (q_a.size() == 0 && ready_a)) && n < 400);
    if (n >= 400) fail_now("done_timeout");
  endtask

  initial begin : mon_a
    sym_t e;
    sym_t saved;
    logic held;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) check("hold_a", 32'({cv_a, r_a, c_a, last_a}), 32'({1'b1, saved}));
        held  = cv_a && !cr_a;
        saved = {r_a, c_a, last_a};
        if (cv_a && cr_a) begin
          if (q_a.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL extra_sym_a: actual=%0h required=none", {r_a, c_a, last_a});
          end else begin
            e = q_a.pop_front();
            check("sym_a", 32'({r_a, c_a, last_a}), 32'(e));
          end
        end
      end
    end
  end

  initial begin : mon_b
    sym_t e;
    forever begin
      @(negedge clk);
      if (!rst && cv_b && cr_b) begin
        if (q_b.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_sym_b: actual=%0h required=none", {r_b, c_b, last_b});
        end else begin
          e = q_b.pop_front();
          check("sym_b", 32'({r_b, c_b, last_b}), 32'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [511:0] b;
    rst      = 1'b1;
    valid_a  = 1'b0;
    valid_b  = 1'b0;
    cr_a     = 1'b1;
    cr_b     = 1'b1;
    block_in = '0;
    repeat (3) @(negedge clk);
    check("rst_block_ready", 32'(ready_a), 32'd1);
    check("rst_coef_valid", 32'(cv_a), 32'd0);
    check("rst_r_value", 32'(r_a), 32'd0);
    check("rst_coefficient", 32'(c_a), 32'd0);
    check("rst_last", 32'(last_a), 32'd0);
    check("rst_block_ready_b", 32'(ready_b), 32'd1);
    rst = 1'b0;

    // DC only: 32/16 = 2, then repeat gives zero difference.
    b = '0; b[0*8 +: 8] = 8'd32;
    expect_sym(0, 4'd0, 8'd2, 1'b0); expect_sym(0, 4'd0, 8'd0, 1'b1);
    send(0, b); wait_done(0);
    expect_sym(0, 4'd0, 8'd0, 1'b0); expect_sym(0, 4'd0, 8'd0, 1'b1);
    send(0, b); wait_done(0);

    // Single AC: 55/11 -> 5; DC 0 - 2 = -2.
    b = '0; b[1*8 +: 8] = 8'd55;
    expect_sym(0, 4'd0, 8'hFE, 1'b0); expect_sym(0, 4'd0, 8'd5, 1'b0); expect_sym(0, 4'd0, 8'd0, 1'b1);
    send(0, b); wait_done(0);

    // Zig-zag 20 after 19 zeros: ZRL then run 3, value 48/24 = 2.
    b = '0; b[40*8 +: 8] = 8'd48;
    expect_sym(0, 4'd0, 8'd0, 1'b0); expect_sym(0, 4'd15, 8'd0, 1'b0);
    expect_sym(0, 4'd3, 8'd2, 1'b0); expect_sym(0, 4'd0, 8'd0, 1'b1);
    send(0, b); wait_done(0);

    // Position 63: three ZRLs, then (14,1) as last, no EOB.
    b = '0; b[63*8 +: 8] = 8'd99;
    expect_sym(0, 4'd0, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) expect_sym(0, 4'd15, 8'd0, 1'b0);
    expect_sym(0, 4'd14, 8'd1, 1'b1);
    send(0, b); wait_done(0);

    // Rounding and backpressure: -8 -> 0, 55 -> 5, -30/10 -> -3 at zig-zag 5.
    b = '0; b[0*8 +: 8] = 8'hF8; b[1*8 +: 8] = 8'd55; b[2*8 +: 8] = 8'hE2;
    expect_sym(0, 4'd0, 8'd0, 1'b0); expect_sym(0, 4'd0, 8'd5, 1'b0);
    expect_sym(0, 4'd3, 8'hFD, 1'b0); expect_sym(0, 4'd0, 8'd0, 1'b1);
    send(0, b);
    @(posedge clk); #1;
    cr_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cr_a = 1'b1;
    wait_done(0);

    // 8/16 rounds up to 1.
    b = '0; b[0*8 +: 8] = 8'd8;
    expect_sym(0, 4'd0, 8'd1, 1'b0); expect_sym(0, 4'd0, 8'd0, 1'b1);
    send(0, b); wait_done(0);

    // Reset mid-EMIT: DC difference 2 - 1 = 1 is consumed, rest discarded.
    b = '0; b[0*8 +: 8] = 8'd32; b[63*8 +: 8] = 8'd99;
    expect_sym(0, 4'd0, 8'd1, 1'b0);
    for (int i = 0; i < 3; i++) expect_sym(0, 4'd15, 8'd0, 1'b0);
    expect_sym(0, 4'd14, 8'd1, 1'b1);
    send(0, b);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_coef_valid", 32'(cv_a), 32'd0);
    check("midrst_block_ready", 32'(ready_a), 32'd1);
    check("midrst_r_value", 32'(r_a), 32'd0);
    check("midrst_coefficient", 32'(c_a), 32'd0);
    check("midrst_last", 32'(last_a), 32'd0);
    check("midrst_consumed", 32'(q_a.size()), 32'd4);
    q_a.delete();
    @(negedge clk);
    rst = 1'b0;
    b = '0; b[0*8 +: 8] = 8'd32;
    expect_sym(0, 4'd0, 8'd2, 1'b0); expect_sym(0, 4'd0, 8'd0, 1'b1);
    send(0, b); wait_done(0);

    // Bypass: values pass through unchanged.
    b = '0; b[0*8 +: 8] = 8'hFB; b[1*8 +: 8] = 8'd100; b[8*8 +: 8] = 8'h80; b[63*8 +: 8] = 8'h7F;
    expect_sym(1, 4'd0, 8'hFB, 1'b0); expect_sym(1, 4'd0, 8'd100, 1'b0); expect_sym(1, 4'd0, 8'h80, 1'b0);
    for (int i = 0; i < 3; i++) expect_sym(1, 4'd15, 8'd0, 1'b0);
    expect_sym(1, 4'd12, 8'h7F, 1'b1);
    send(1, b); wait_done(1);

    repeat (4) @(negedge clk);
    check("queue_a_drained", 32'(q_a.size()), 32'd0);
    check("queue_b_drained", 32'(q_b.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
